// File: rtl/alu_sequencer.sv
// Purpose : fetch/issue/writeback sequencer that drives an external 8-bit ALU from a small program memory.
// Latency : 4 cycles per instruction (FETCH, ISSUE, WAIT, WB); N instructions take 4N+1 cycles from start to done.
// Backpres: none; host loads and start are only accepted while idle (busy=0), otherwise silently dropped.
//
// Ports:
//   clk, reset                         clock and asynchronous active-high reset
//   start                              begin execution at pc=0 (sampled in IDLE only)
//   prog_we/prog_addr/prog_wdata       program memory load port (idle only)
//   reg_we/reg_addr/reg_wdata          register file load port (idle only)
//   reg_rdata                          combinational rf[reg_addr]
//   alu_opcode/alu_a/alu_b             registered operands presented to the ALU
//   alu_result                         ALU output, captured at the WB edge
//   result/result_valid                last written-back value and its one-cycle pulse
//   busy/done                          state != IDLE / state == DONE
module alu_sequencer #(
   parameter int PROG_DEPTH = 16,
   parameter int NREGS      = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          prog_we,
   input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
   input  logic [15:0]                   prog_wdata,
   input  logic                          reg_we,
   input  logic [$clog2(NREGS)-1:0]      reg_addr,
   input  logic [7:0]                    reg_wdata,
   output logic [7:0]                    reg_rdata,
   output logic [3:0]                    alu_opcode,
   output logic [7:0]                    alu_a,
   output logic [7:0]                    alu_b,
   input  logic [7:0]                    alu_result,
   output logic [7:0]                    result,
   output logic                          result_valid,
   output logic                          busy,
   output logic                          done
);

   localparam int PW = $clog2(PROG_DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_WAIT,
      S_WB,
      S_DONE
   } state_t;

   state_t state, state_nxt;

   logic [15:0]   prog [PROG_DEPTH];
   logic [7:0]    rf   [NREGS];
   logic [PW-1:0] pc;
   // Only the decoded fields are kept; bits [4:0] of the word are reserved.
   logic [15:5]   ir;

   logic [3:0] ir_op;
   logic [1:0] ir_ra, ir_rb, ir_rd;
   logic       ir_halt;
   logic       last_instr;

   assign ir_op   = ir[15:12];
   assign ir_ra   = ir[11:10];
   assign ir_rb   = ir[9:8];
   assign ir_rd   = ir[7:6];
   assign ir_halt = ir[5];

   // Stop on the halt bit or at the last program slot: pc never wraps.
   assign last_instr = ir_halt || (pc == PW'(PROG_DEPTH - 1));

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign reg_rdata = rf[reg_addr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT:  state_nxt = S_WB;
         S_WB:    state_nxt = last_instr ? S_DONE : S_FETCH;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Program memory is deliberately not reset so a loaded program survives reset.
   always_ff @(posedge clk) begin
      if (prog_we && state == S_IDLE) prog[prog_addr] <= prog_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc           <= '0;
         ir           <= '0;
         alu_opcode   <= '0;
         alu_a        <= '0;
         alu_b        <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf[i] <= '0;
      end else begin
         result_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (reg_we) rf[reg_addr] <= reg_wdata;
               if (start)  pc <= '0;
            end
            S_FETCH: ir <= prog[pc][15:5];
            S_ISSUE: begin
               // Operands are captured here, so rd may alias ra/rb safely.
               alu_opcode <= ir_op;
               alu_a      <= rf[ir_ra];
               alu_b      <= rf[ir_rb];
            end
            S_WB: begin
               rf[ir_rd]    <= alu_result;
               result       <= alu_result;
               result_valid <= 1'b1;
               pc           <= pc + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Purpose : directed self-checking bench for alu_sequencer with a small registered ALU model.
// Latency : ALU model registers opcode/A/B every rising edge, so its output is valid one cycle later.
// Backpres: none; stimulus is driven on the falling edge and outputs are sampled there too.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        prog_we;
   logic [3:0]  prog_addr;
   logic [15:0] prog_wdata;
   logic        reg_we;
   logic [1:0]  reg_addr;
   logic [7:0]  reg_wdata;
   logic [7:0]  reg_rdata;
   logic [3:0]  alu_opcode;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [7:0]  alu_result;
   logic [7:0]  result;
   logic        result_valid;
   logic        busy;
   logic        done;

   always #5 clk = ~clk;

   alu_sequencer #(.PROG_DEPTH(16), .NREGS(4)) dut (
      .clk(clk), .reset(reset), .start(start),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
      .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
      .result(result), .result_valid(result_valid), .busy(busy), .done(done)
   );

   // Registered ALU: 0 ADD, 1 SUB, 2 MUL (low byte), 3 AND, others XOR.
   always_ff @(posedge clk) begin
      case (alu_opcode)
         4'h0:    alu_result <= alu_a + alu_b;
         4'h1:    alu_result <= alu_a - alu_b;
         4'h2:    alu_result <= alu_a * alu_b;
         4'h3:    alu_result <= alu_a & alu_b;
         default: alu_result <= alu_a ^ alu_b;
      endcase
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   int         done_cyc;
   int         nvalid;
   logic [7:0] res_q[$];
   logic [3:0] cap_op;
   logic [7:0] cap_a, cap_b;

   task automatic wreg(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      @(negedge clk);
      reg_we = 1'b0;
   endtask

   task automatic wprog(input logic [3:0] a, input logic [15:0] d);
      @(negedge clk);
      prog_we = 1'b1; prog_addr = a; prog_wdata = d;
      @(negedge clk);
      prog_we = 1'b0;
   endtask

   task automatic rreg(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      reg_addr = a;
      #1 d = reg_rdata;
   endtask

   // Pulse start and observe until done or budget expiry. Cycle 1 is the cycle
   // after the start edge. inj_cyc>0 drives start/prog_we/reg_we in that cycle.
   task automatic run(input int max_cyc, input int inj_cyc);
      done_cyc = 0;
      nvalid   = 0;
      res_q.delete();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         if (cyc == 3) begin
            cap_op = alu_opcode; cap_a = alu_a; cap_b = alu_b;
         end
         if (result_valid) begin
            nvalid++;
            res_q.push_back(result);
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
         if (cyc == inj_cyc) begin
            start = 1'b1;
            prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = 16'hFFFF;
            reg_we = 1'b1; reg_addr = 2'd0; reg_wdata = 8'h77;
         end
         @(negedge clk);
         start = 1'b0; prog_we = 1'b0; reg_we = 1'b0;
      end
      @(negedge clk);
      chk("busy_after_done", {31'd0, busy}, 32'd0);
      chk("done_one_cycle", {31'd0, done}, 32'd0);
   endtask

   logic [7:0] rv;
   int         bad;

   initial begin
      reset = 1'b1; start = 1'b0;
      prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
      reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_opcode", {28'd0, alu_opcode}, 32'd0);
      chk("rst_a", {24'd0, alu_a}, 32'd0);
      chk("rst_b", {24'd0, alu_b}, 32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         rreg(i[1:0], rv);
         chk($sformatf("rst_rf%0d", i), {24'd0, rv}, 32'd0);
      end

      // ADD r0,r1->r2 with halt.
      wreg(2'd0, 8'd5); wreg(2'd1, 8'd3); wprog(4'd0, 16'h01A0);
      run(20, 0);
      chk("t1_op", {28'd0, cap_op}, 32'd0);
      chk("t1_a", {24'd0, cap_a}, 32'd5);
      chk("t1_b", {24'd0, cap_b}, 32'd3);
      chk("t1_nvalid", nvalid, 1);
      chk("t1_result", {24'd0, result}, 32'd8);
      chk("t1_done_cyc", done_cyc, 5);
      rreg(2'd2, rv);
      chk("t1_r2", {24'd0, rv}, 32'd8);

      // SUB r0,r1->r3 then MUL r3,r1->r0 with halt.
      wprog(4'd0, 16'h11C0); wprog(4'd1, 16'h2D20);
      wreg(2'd0, 8'd5); wreg(2'd1, 8'd3);
      run(30, 0);
      chk("t2_nvalid", nvalid, 2);
      if (nvalid == 2) begin
         chk("t2_res0", {24'd0, res_q[0]}, 32'd2);
         chk("t2_res1", {24'd0, res_q[1]}, 32'd6);
      end
      chk("t2_done_cyc", done_cyc, 9);
      rreg(2'd0, rv);
      chk("t2_r0", {24'd0, rv}, 32'd6);
      rreg(2'd3, rv);
      chk("t2_r3", {24'd0, rv}, 32'd2);

      // 16 x AND r0,r0->r0 without halt: runs to the last slot.
      for (int i = 0; i < 16; i++) wprog(i[3:0], 16'h3000);
      wreg(2'd0, 8'hA5);
      run(100, 0);
      chk("t3_nvalid", nvalid, 16);
      chk("t3_done_cyc", done_cyc, 65);
      bad = 0;
      foreach (res_q[i]) if (res_q[i] !== 8'hA5) bad++;
      chk("t3_res_all", bad, 0);
      rreg(2'd0, rv);
      chk("t3_r0", {24'd0, rv}, 32'hA5);

      // start/prog_we/reg_we while busy (WAIT) are ignored.
      wprog(4'd0, 16'h01A0);
      wreg(2'd0, 8'd5); wreg(2'd1, 8'd3);
      run(20, 3);
      chk("t4_done_cyc", done_cyc, 5);
      chk("t4_nvalid", nvalid, 1);
      chk("t4_result", {24'd0, result}, 32'd8);
      rreg(2'd0, rv);
      chk("t4_r0_kept", {24'd0, rv}, 32'd5);
      run(20, 0);
      chk("t4_rb_op", {28'd0, cap_op}, 32'd0);
      chk("t4_rb_result", {24'd0, result}, 32'd8);
      chk("t4_rb_done_cyc", done_cyc, 5);

      // Reset during WAIT of instruction 0.
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("t5_pre_busy", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("t5_busy", {31'd0, busy}, 32'd0);
      chk("t5_a", {24'd0, alu_a}, 32'd0);
      chk("t5_b", {24'd0, alu_b}, 32'd0);
      chk("t5_result", {24'd0, result}, 32'd0);
      chk("t5_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (result_valid || busy) bad++;
      end
      chk("t5_quiet", bad, 0);
      for (int i = 0; i < 4; i++) begin
         rreg(i[1:0], rv);
         chk($sformatf("t5_rf%0d", i), {24'd0, rv}, 32'd0);
      end
      wreg(2'd0, 8'd5); wreg(2'd1, 8'd3);
      run(20, 0);
      chk("t5_rerun_a", {24'd0, cap_a}, 32'd5);
      chk("t5_rerun_result", {24'd0, result}, 32'd8);
      chk("t5_rerun_done_cyc", done_cyc, 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Program sequencer that drives the 8-bit ALU from the issuing side: fetches 16-bit instructions from a small internal program memory, reads operands from a 4-entry register file, presents opcode/A/B to the ALU, and writes the registered ALU result back. It sits between a host load port and the ALU's opcode/A/B/ALU_Out ports, turning the ALU into a tiny programmable datapath.

## Interface
Parameters:
- PROG_DEPTH, 16, program memory entries; pc width is log2(PROG_DEPTH).
- NREGS, 4, register file entries, 8 bits each; register select fields are 2 bits.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  begins execution at pc=0; sampled in IDLE only.
- prog_we  input  1  program memory write strobe; honoured only when busy=0.
- prog_addr  input  4  program memory write address.
- prog_wdata  input  16  instruction word.
- reg_we  input  1  register file write strobe; honoured only when busy=0.
- reg_addr  input  2  register file write/read address.
- reg_wdata  input  8  register write data.
- reg_rdata  output  8  combinational rf[reg_addr].
- alu_opcode  output  4  to ALU opcode; registered.
- alu_a  output  8  to ALU A; registered.
- alu_b  output  8  to ALU B; registered.
- alu_result  input  8  from ALU_Out.
- result  output  8  last written-back value; registered.
- result_valid  output  1  one-cycle pulse after each writeback.
- busy  output  1  state != IDLE.
- done  output  1  high for exactly the one cycle in state DONE.

## Operation
- Instruction: [15:12] opcode, [11:10] ra, [9:8] rb, [7:6] rd, [5] halt, [4:0] reserved (ignored).
- States: IDLE, FETCH, ISSUE, WAIT, WB, DONE.
- IDLE: start=1 -> pc<=0, FETCH. Load ports active only here.
- FETCH: ir<=prog[pc]; -> ISSUE.
- ISSUE: alu_opcode<=ir.op, alu_a<=rf[ra], alu_b<=rf[rb]; -> WAIT.
- WAIT: ALU samples opcode/A/B on this edge; -> WB.
- WB: rf[rd]<=alu_result, result<=alu_result, result_valid<=1, pc<=pc+1; if halt=1 or pc==PROG_DEPTH-1 -> DONE, else -> FETCH.
- DONE: -> IDLE.
- Opcode passed through unmodified; all 16 ALU ops legal. ALU-internal accumulator state (ADDA/MULA/MAC) is owned by the ALU; the sequencer neither models nor clears it.
- Writeback to ra/rb of the same instruction is fine: operands were captured in ISSUE.
- pc does not wrap: running past the last entry forces DONE.
- start while busy=1 ignored; prog_we/reg_we while busy=1 ignored (no write).

## Timing
- Reset values: alu_opcode=0, alu_a=0, alu_b=0, result=0, result_valid=0, busy=0, done=0, state IDLE, pc=0, ir=0, rf all 0. Program memory not reset (contents retained).
- Reset mid-program: immediate return to IDLE with values above; no further writeback.
- 4 cycles per instruction (FETCH, ISSUE, WAIT, WB); N instructions: start edge to done = 4N+1 cycles.
- ALU latency: operands valid after ISSUE edge, ALU registers at WAIT edge, alu_result captured at WB edge.
- result_valid high the cycle following each WB edge (coincides with FETCH or DONE).
- A write in the cycle start is sampled is honoured (still IDLE); fetch of pc 0 happens next cycle.

## Test plan
- Load r0=5, r1=3, prog[0]=0x01A0 (ADD r0,r1->r2, halt), pulse start -> alu_opcode=0, alu_a=5, alu_b=3 after ISSUE; r2=8, result=8, one result_valid pulse, done 5 cycles after start edge, busy then 0.
- prog[0]=0x11C0 (SUB r0,r1->r3), prog[1]=0x2D20 (MUL r3,r1->r0, halt), r0=5, r1=3 -> result pulses 2 then 6; reg_rdata(r0)=6 after done; done at cycle 9.
- 16 instructions without halt bit (all AND r0,r0->r0, r0=0xA5) -> 16 result_valid pulses, done after pc=15, r0=0xA5.
- Assert start and prog_we (addr 0, data 0xFFFF) during WAIT -> no restart, prog[0] unchanged on readback run.
- Assert reset during WAIT of instruction 0 -> all outputs zero immediately, rf cleared, no result_valid, subsequent start re-executes program from pc=0.
